// File: rtl/metro_scroller.sv
// metro_scroller: scrolls a message index window across a 4-digit multiplexed display.
module metro_scroller #(
  parameter int SCROLL_DIV  = 50000000,
  parameter int REFRESH_DIV = 100000,
  parameter int MSG_LEN     = 19,
  parameter int HOLD_TICKS  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  output logic [10:0] y,
  output logic [3:0]  an,
  output logic        busy,
  output logic        done
);
  localparam int SW = $clog2(SCROLL_DIV);
  localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [SW-1:0] S_MAX = SW'(SCROLL_DIV - 1);
  localparam logic [RW-1:0] R_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [HW-1:0] H_END = HW'(HOLD_TICKS);
  localparam logic [10:0] P_END = MSG_LEN > 4 ? 11'(MSG_LEN - 4) : 11'd0;
  localparam logic [11:0] LEN = 12'(MSG_LEN);
  typedef enum logic [1:0] {IDLE, SCROLL, HOLD, DONE} state_t;
  state_t state_q, state_d;
  logic [10:0] pos_q, pos_d, y_q, y_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [1:0] d_q, d_d;
  logic [3:0] an_q, an_d;
  logic busy_q, busy_d, done_q, done_d, run, tick;
  logic [11:0] sum;
  always_comb begin
    rcnt_d = rcnt_q == R_MAX ? '0 : rcnt_q + 1'b1;
    d_d = rcnt_q == R_MAX ? d_q + 2'd1 : d_q;
    run = state_q == SCROLL || state_q == HOLD;
    tick = run && !pause && scnt_q == S_MAX;
    scnt_d = run && !pause ? (tick ? '0 : scnt_q + 1'b1) : scnt_q;
    state_d = state_q;
    pos_d = pos_q;
    hcnt_d = hcnt_q;
    case (state_q)
      IDLE: begin
        pos_d = '0;
        hcnt_d = '0;
        scnt_d = '0;
        if (start) state_d = MSG_LEN <= 4 ? HOLD : SCROLL;
      end
      SCROLL: if (tick) begin
        pos_d = pos_q + 11'd1;
        if (pos_d == P_END) state_d = HOLD;
      end
      HOLD: if (tick) begin
        hcnt_d = hcnt_q + 1'b1;
        if (hcnt_d == H_END) state_d = DONE;
      end
      default: begin
        state_d = IDLE;
        pos_d = '0;
      end
    endcase
    // window index is formed one bit wider so the pad test never sees a wrapped value
    sum = {1'b0, pos_d} + {10'd0, d_d};
    busy_d = state_d == SCROLL || state_d == HOLD;
    done_d = state_d == DONE;
    y_d = busy_d && sum < LEN ? sum[10:0] : '0;
    an_d = ~(4'b1000 >> d_d);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pos_q <= '0;
      scnt_q <= '0;
      rcnt_q <= '0;
      hcnt_q <= '0;
      d_q <= '0;
      an_q <= 4'b0111;
      y_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q <= pos_d;
      scnt_q <= scnt_d;
      rcnt_q <= rcnt_d;
      hcnt_q <= hcnt_d;
      d_q <= d_d;
      an_q <= an_d;
      y_q <= y_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign y = y_q;
  assign an = an_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
